quad_encoder: RTL and testbench
===============================

# quad_encoder

Quadrature rotary-encoder decoder sitting directly downstream of the per-pin debouncers. It consumes the debounced A and B phases of one encoder and classifies each phase transition as forward, reverse or illegal. It accumulates detents into a WIDTH-bit value, either wrapping or saturating, which feeds the PWM/colour stage. It also emits a one-cycle step strobe with direction, and an error strobe for illegal transitions.

## Interface
- WIDTH, 8: width of the accumulated value.
- INCREMENT, 1: amount added or subtracted per step, range 1 to 2^WIDTH-1.
- SATURATE, 0: 0 means the value wraps modulo 2^WIDTH; 1 means it clamps at 0 and 2^WIDTH-1.
- X4, 0: 0 means one step per full quadrature cycle (4 edges); 1 means one step per legal edge.
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- a  input  1  debounced phase A, already synchronous to clk.
- b  input  1  debounced phase B, already synchronous to clk.
- value  output  WIDTH  accumulated encoder position.
- step  output  1  one-cycle strobe, high on the cycle a step is detected.
- dir  output  1  direction of the last step (1 = forward, 0 = reverse); holds between steps.
- err  output  1  one-cycle strobe on an illegal transition (both phases changed at once).

## Operation
- The phase state is the 2-bit value {a,b}.
- Forward sequence: 00→10→11→01→00, meaning A leads B.
- Reverse sequence: 00→01→11→10→00.
- States:
  - INIT: entered on reset. On the first non-reset cycle, prev is loaded from {a,b}. No count and no err. Moves to RUN.
  - RUN: each cycle the block compares {a,b} with prev, then sets prev to {a,b}.
    - No change: nothing happens.
    - Legal forward edge: sub increments by 1.
    - Legal reverse edge: sub decrements by 1.
    - Illegal edge (00↔11 or 01↔10): err strobes for 1 cycle, sub clears to 0, value is unchanged.
- sub is a signed 3-bit edge accumulator.
  - When X4=1, every legal edge is a step immediately and sub stays 0.
  - When X4=0, a step occurs when sub reaches +4 (forward) or -4 (reverse); sub then clears to 0.
  - A partial rotation that reverses direction therefore cancels with no step.
- On a step:
  - step is high for 1 cycle and dir takes the step direction.
  - value ± INCREMENT is computed at WIDTH+1 bits.
  - With SATURATE=0, value takes the low WIDTH bits.
  - With SATURATE=1, a result outside the range clamps to 0 or 2^WIDTH-1.
  - step still strobes when the value is clamped, including when it is already at a limit.
- Reset values: value=0, step=0, dir=0, err=0, sub=0, prev=00, state=INIT.
- Reset has priority. Asserting reset mid-rotation discards the partial sub, zeroes value, and returns to INIT.

## Timing
- Inputs are sampled at every rising clk edge.
- value, step, dir and err are registered and update on the same edge that samples the transition. Latency is 1 cycle from an input change to the output.
- Only one transition is evaluated per cycle. The input contract is at most 1 phase change per cycle after debouncing; a double change in one cycle is reported as err.
- step and err are never high in the same cycle.
- The first cycle after reset deassertion is always INIT: no step and no err, regardless of {a,b}.
- When X4=0, a full forward cycle sampled at cycles N..N+3 produces step on the edge sampling the 4th transition.

## Structure
- The shared package rgb_mixer_pkg holds:
  - direction constants DIR_FWD=1 and DIR_REV=0;
  - the 2-bit enum for the transition class: NONE, FWD, REV, ILLEGAL;
  - the INIT/RUN state enum.
- Sub-module quad_step_detect is purely combinational. Its inputs are prev and {a,b}; its output is the transition class.
- quad_encoder owns prev, sub, the state machine, the accumulator and the output registers.

## Test plan
- Reset, then hold {a,b}=11 for 10 cycles: value=0, no step, no err, including in the INIT cycle.
- X4=0, INCREMENT=1: drive 3 full forward cycles (12 edges), 2 clk cycles per phase: value=3, exactly 3 step pulses, dir=1.
- X4=0: drive forward 00→10→11 and then back 11→10→00: value unchanged, no step.
- X4=1, SATURATE=0, WIDTH=8: from value=0, drive 1 reverse edge: value=255, step=1, dir=0. Then drive 1 forward edge: value=0.
- SATURATE=1, INCREMENT=16: drive 20 forward steps: value=255 with 20 step pulses. Then drive 1 reverse step: value=239.
- Illegal 00→11 after 2 forward edges (X4=0): err is high 1 cycle, sub cleared. The next 4 forward edges produce exactly 1 step. Asserting reset mid-cycle gives value=0 on the next cycle.

Source files
------------

// File: rtl/rgb_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rgb_mixer_pkg
// Description : Shared types for the rotary-encoder front end of the RGB
//               mixer: step direction constants, quadrature transition
//               classes and the decoder state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_mixer_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Classification of one {a,b} sample against the previous one.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    FWD     = 2'd1,
    REV     = 2'd2,
    ILLEGAL = 2'd3
  } trans_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Position of a phase pair along the forward sequence 00,10,11,01.
  // Forward motion adds 1 (mod 4), reverse subtracts 1, and a distance
  // of 2 means both phases toggled at once.
  function automatic logic [1:0] phase_pos(input logic [1:0] i_ab);
    return {i_ab[0], i_ab[1] ^ i_ab[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_step_detect.sv
`default_nettype none
// ============================================================================
// Module      : quad_step_detect
// Description : Combinational classifier for one quadrature transition.
// Ports       : i_prev  - previous {a,b} sample
//               i_cur   - current  {a,b} sample
//               o_trans - NONE / FWD / REV / ILLEGAL
// Revision    : 1.0 - initial release
// ============================================================================
module quad_step_detect
  import rgb_mixer_pkg::*;
(
  input  logic [1:0] i_prev,
  input  logic [1:0] i_cur,
  output trans_t     o_trans
);

  logic [1:0] w_delta;

  assign w_delta = phase_pos(i_cur) - phase_pos(i_prev);

  always_comb begin
    o_trans = NONE;
    case (w_delta)
      2'd1:    o_trans = FWD;
      2'd3:    o_trans = REV;
      2'd2:    o_trans = ILLEGAL;
      default: o_trans = NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/quad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder
// Description : Quadrature rotary-encoder decoder. Classifies debounced A/B
//               transitions, accumulates detents into a wrapping or
//               saturating position value and strobes step / err.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               a, b  - debounced phases, synchronous to clk
//               value - accumulated position (WIDTH bits)
//               step  - one-cycle strobe per detected step
//               dir   - direction of last step (1 = forward)
//               err   - one-cycle strobe on an illegal transition
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int INCREMENT = 1,
  parameter int SATURATE  = 0,
  parameter int X4        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] value,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [WIDTH:0] c_inc = (WIDTH+1)'(INCREMENT);
  localparam logic [WIDTH:0] c_max = {1'b0, {WIDTH{1'b1}}};

  state_t            r_state;
  logic [1:0]        r_prev;
  logic signed [2:0] r_sub;
  logic [WIDTH-1:0]  r_value;
  logic              r_step;
  logic              r_dir;
  logic              r_err;

  state_t            w_state_nxt;
  logic [1:0]        w_prev_nxt;
  logic signed [2:0] w_sub_nxt;
  logic signed [3:0] w_sub_ext;
  logic [WIDTH-1:0]  w_value_nxt;
  logic              w_step_nxt;
  logic              w_dir_nxt;
  logic              w_err_nxt;
  logic              w_take;
  logic              w_fwd;
  logic [1:0]        w_ab;
  trans_t            w_trans;
  logic [WIDTH:0]    w_up;
  logic [WIDTH:0]    w_dn;

  assign w_ab = {a, b};

  quad_step_detect u_detect (
    .i_prev  (r_prev),
    .i_cur   (w_ab),
    .o_trans (w_trans)
  );

  // One guard bit above the value: bit WIDTH flags overflow on the way up
  // and borrow (negative result) on the way down.
  assign w_up = {1'b0, r_value} + c_inc;
  assign w_dn = {1'b0, r_value} - c_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_prev  <= 2'b00;
      r_sub   <= 3'sd0;
      r_value <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_sub   <= w_sub_nxt;
      r_value <= w_value_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_sub_nxt   = r_sub;
    w_value_nxt = r_value;
    w_step_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_err_nxt   = 1'b0;
    w_take      = 1'b0;
    w_fwd       = 1'b0;
    // Sign-extended so that +4 is representable before the clear.
    w_sub_ext   = {r_sub[2], r_sub};

    case (r_state)
      INIT: begin
        w_prev_nxt  = w_ab;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_prev_nxt = w_ab;
        case (w_trans)
          FWD, REV: begin
            w_fwd = (w_trans == FWD);
            if (X4 != 0) begin
              w_take = 1'b1;
            end else begin
              w_sub_ext = w_fwd ? (w_sub_ext + 4'sd1) : (w_sub_ext - 4'sd1);
              if ((w_sub_ext == 4'sd4) || (w_sub_ext == -4'sd4)) begin
                w_take    = 1'b1;
                w_sub_nxt = 3'sd0;
              end else begin
                w_sub_nxt = w_sub_ext[2:0];
              end
            end
          end
          ILLEGAL: begin
            w_err_nxt = 1'b1;
            w_sub_nxt = 3'sd0;
          end
          default: ;
        endcase
      end
      default: w_state_nxt = INIT;
    endcase

    if (w_take) begin
      w_step_nxt = 1'b1;
      w_dir_nxt  = w_fwd ? DIR_FWD : DIR_REV;
      if (w_fwd) begin
        w_value_nxt = ((SATURATE != 0) && w_up[WIDTH]) ? c_max[WIDTH-1:0]
                                                        : w_up[WIDTH-1:0];
      end else begin
        w_value_nxt = ((SATURATE != 0) && w_dn[WIDTH]) ? '0
                                                        : w_dn[WIDTH-1:0];
      end
    end
  end

  assign value = r_value;
  assign step  = r_step;
  assign dir   = r_dir;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_encoder
// Description : Self-checking bench for quad_encoder. Four instances share the
//               same A/B/reset stimulus and cover the parameter corners
//               (X4 = g%2, SATURATE = g/2, INCREMENT = 16 when saturating).
//               A behavioural model tracks each instance cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             a     = 1'b0;
  logic             b     = 1'b0;
  logic [3:0][7:0]  val_o;
  logic [3:0]       step_o;
  logic [3:0]       dir_o;
  logic [3:0]       err_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    quad_encoder #(
      .WIDTH     (8),
      .INCREMENT (((g / 2) != 0) ? 16 : 1),
      .SATURATE  (g / 2),
      .X4        (g % 2)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .value (val_o[g]),
      .step  (step_o[g]),
      .dir   (dir_o[g]),
      .err   (err_o[g])
    );
  end

  // Forward successor of each phase pair (00->10->11->01->00) and its inverse.
  int FN [4] = '{2, 0, 3, 1};
  int RV [4] = '{1, 3, 0, 2};

  int   m_val  [4];
  int   m_sub  [4];
  int   m_prev [4];
  bit   m_init [4];
  bit   m_step [4];
  bit   m_dir  [4];
  bit   m_err  [4];
  int   step_cnt [4];
  int   err_cnt  [4];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] cur = 2'b00;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input int i, input logic r, input logic [1:0] ab);
    int d;
    int v;
    int inc;
    bit take;
    m_step[i] = 1'b0;
    m_err[i]  = 1'b0;
    if (r) begin
      m_val[i] = 0; m_sub[i] = 0; m_prev[i] = 0; m_init[i] = 1'b1; m_dir[i] = 1'b0;
      return;
    end
    if (m_init[i]) begin
      m_prev[i] = int'(ab);
      m_init[i] = 1'b0;
      return;
    end
    d    = 0;
    take = 1'b0;
    if (int'(ab) == m_prev[i])          d = 0;
    else if (FN[m_prev[i]] == int'(ab)) d = 1;
    else if (FN[int'(ab)] == m_prev[i]) d = -1;
    else begin
      m_err[i] = 1'b1;
      m_sub[i] = 0;
    end
    m_prev[i] = int'(ab);
    if (d != 0) begin
      if ((i % 2) == 1) take = 1'b1;
      else begin
        m_sub[i] += d;
        if (m_sub[i] == 4 || m_sub[i] == -4) begin
          take     = 1'b1;
          m_sub[i] = 0;
        end
      end
    end
    if (take) begin
      inc = ((i / 2) != 0) ? 16 : 1;
      v   = m_val[i] + d * inc;
      if ((i / 2) != 0) begin
        if (v > 255) v = 255;
        if (v < 0)   v = 0;
      end else begin
        v = ((v % 256) + 256) % 256;
      end
      m_val[i]  = v;
      m_step[i] = 1'b1;
      m_dir[i]  = (d > 0);
    end
  endfunction

  task automatic tick(input logic r, input logic [1:0] ab);
    reset = r;
    a     = ab[1];
    b     = ab[0];
    cur   = ab;
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i, r, ab);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d.value", i), int'(val_o[i]),  m_val[i]);
      check($sformatf("d%0d.step",  i), int'(step_o[i]), int'(m_step[i]));
      check($sformatf("d%0d.dir",   i), int'(dir_o[i]),  int'(m_dir[i]));
      check($sformatf("d%0d.err",   i), int'(err_o[i]),  int'(m_err[i]));
      step_cnt[i] += int'(step_o[i]);
      err_cnt[i]  += int'(err_o[i]);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      step_cnt[i] = 0;
      err_cnt[i]  = 0;
    end
  endtask

  task automatic fwd(input int n, input int hold);
    logic [1:0] nx;
    repeat (n) begin
      nx = 2'(FN[int'(cur)]);
      repeat (hold) tick(1'b0, nx);
    end
  endtask

  task automatic rev(input int n, input int hold);
    logic [1:0] nx;
    repeat (n) begin
      nx = 2'(RV[int'(cur)]);
      repeat (hold) tick(1'b0, nx);
    end
  endtask

  initial begin
    int k;
    logic r;
    logic [1:0] nx;
    clear_counts();

    // Reset, then hold 11: nothing happens, including the INIT cycle.
    tick(1'b1, 2'b11);
    tick(1'b1, 2'b11);
    check("rst_value", int'(val_o[0]), 0);
    check("rst_step",  int'(step_o[0]), 0);
    check("rst_dir",   int'(dir_o[0]), 0);
    clear_counts();
    repeat (10) tick(1'b0, 2'b11);
    check("hold_steps", step_cnt[0], 0);
    check("hold_errs",  err_cnt[0], 0);
    check("hold_value", int'(val_o[0]), 0);

    // Three full forward cycles, 2 clocks per phase.
    tick(1'b1, 2'b00);
    tick(1'b0, 2'b00);
    clear_counts();
    fwd(12, 2);
    check("x1_value", int'(val_o[0]), 3);
    check("x1_steps", step_cnt[0], 3);
    check("x1_dir",   int'(dir_o[0]), 1);
    check("x4_value", int'(val_o[1]), 12);
    check("x4_steps", step_cnt[1], 12);
    check("sat_x1_value", int'(val_o[2]), 48);
    check("sat_x4_value", int'(val_o[3]), 192);

    // Partial rotation that reverses cancels without a step.
    clear_counts();
    fwd(2, 1);
    rev(2, 1);
    check("cancel_value", int'(val_o[0]), 3);
    check("cancel_steps", step_cnt[0], 0);
    check("cancel_x4_value", int'(val_o[1]), 12);

    // X4 wrap below zero and back.
    tick(1'b1, 2'b00);
    tick(1'b0, 2'b00);
    rev(1, 1);
    check("wrap_value", int'(val_o[1]), 255);
    check("wrap_step",  int'(step_o[1]), 1);
    check("wrap_dir",   int'(dir_o[1]), 0);
    fwd(1, 1);
    check("wrap_back_value", int'(val_o[1]), 0);

    // Saturation at the top with INCREMENT=16.
    tick(1'b1, 2'b00);
    tick(1'b0, 2'b00);
    clear_counts();
    fwd(80, 1);
    check("sat_steps", step_cnt[2], 20);
    check("sat_value", int'(val_o[2]), 255);
    check("sat_x4_top", int'(val_o[3]), 255);
    check("sat_x4_steps", step_cnt[3], 80);
    rev(4, 1);
    check("sat_rev_value", int'(val_o[2]), 239);
    check("sat_x4_rev_value", int'(val_o[3]), 191);

    // Illegal jump clears the partial count; reset mid-rotation.
    tick(1'b1, 2'b11);
    tick(1'b0, 2'b11);
    fwd(2, 1);
    tick(1'b0, 2'b11);
    check("ill_err",  int'(err_o[0]), 1);
    check("ill_step", int'(step_o[0]), 0);
    tick(1'b0, 2'b11);
    check("ill_err_oneshot", int'(err_o[0]), 0);
    clear_counts();
    fwd(3, 1);
    check("ill_no_early_step", step_cnt[0], 0);
    fwd(1, 1);
    check("ill_one_step", step_cnt[0], 1);
    check("ill_value", int'(val_o[0]), 1);
    fwd(2, 1);
    tick(1'b1, cur);
    check("midrst_value", int'(val_o[0]), 0);
    tick(1'b0, cur);
    check("midrst_init_step", int'(step_o[0]), 0);
    check("midrst_init_err",  int'(err_o[0]), 0);

    // Randomised traffic, forward-biased so the saturating corners are hit.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      k = int'($urandom_range(0, 15));
      if (k <= 4)       nx = cur;
      else if (k <= 10) nx = 2'(FN[int'(cur)]);
      else if (k <= 14) nx = 2'(RV[int'(cur)]);
      else              nx = cur ^ 2'b11;
      tick(r, nx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
